dsp_result_buf: RTL and testbench

DSP_RESULT_BUF -- requirements
Module: dsp_result_buf

---
 rtl/dsp_pkg.sv | 12 +
 rtl/dsp_result_buf.sv | 105 ++++++++++
 tb/tb_dsp_result_buf.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: result-buffer state encoding and the widest supported result word.
package dsp_pkg;

  localparam int DSP_MAX_WIDTH = 48;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/dsp_result_buf.sv
// Two-entry skid buffer for DSP results: push into EMPTY is visible on out_valid one cycle later.
// in_ready and out_valid come straight from flops, so out_ready never reaches in_ready combinationally.
module dsp_result_buf
  import dsp_pkg::*;
#(
  parameter int width = 48
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_zero,
  output logic [15:0]      count
);

  generate
    if ((width < 1) || (width > DSP_MAX_WIDTH)) begin : g_width_chk
      $error("dsp_result_buf: width %0d outside 1..%0d", width, DSP_MAX_WIDTH);
    end
  endgenerate

  buf_state_e       state_q, state_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      count_q, count_d;
  logic             push, pop, load_head;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    load_head = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d    = in_data;
          load_head = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d    = in_data;
          load_head = 1'b1;
        end else if (push) begin
          tail_d  = in_data;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d    = tail_q;
          load_head = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Zero flag tracks whatever was last written into head.
    zero_d      = load_head ? (head_d == '0) : zero_q;
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    count_d     = pop ? (count_q + 16'd1) : count_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;
  assign out_zero  = zero_q;
  assign count     = count_q;

endmodule

// File: tb/tb_dsp_result_buf.sv
// Directed bench for dsp_result_buf: a 48-bit instance for the main behaviour and an 8-bit one for counter wrap.
module tb_dsp_result_buf;

  logic        clk;
  logic        rst, iv, ir, ov, ordy, oz;
  logic [47:0] id, od;
  logic [15:0] cnt;

  logic        rst8, iv8, ir8, ov8, or8, oz8;
  logic [7:0]  id8, od8;
  logic [15:0] cnt8;

  int n_cmp = 0;
  int n_err = 0;

  dsp_result_buf #(.width(48)) dut (
    .clock(clk), .reset(rst),
    .in_valid(iv), .in_ready(ir), .in_data(id),
    .out_valid(ov), .out_ready(ordy), .out_data(od),
    .out_zero(oz), .count(cnt)
  );

  dsp_result_buf #(.width(8)) dut8 (
    .clock(clk), .reset(rst8),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8),
    .out_zero(oz8), .count(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    iv   = 1'b0;
    ordy = 1'b0;
    id   = '0;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; iv = 1'b0; ordy = 1'b0; id = '0;
    rst8 = 1'b0; iv8 = 1'b0; or8 = 1'b0; id8 = '0;
    #1;
    rst  = 1'b1;
    rst8 = 1'b1;
    #2;
    chk("rst_in_ready",  64'(ir),  64'd1);
    chk("rst_out_valid", 64'(ov),  64'd0);
    chk("rst_out_data",  64'(od),  64'd0);
    chk("rst_out_zero",  64'(oz),  64'd0);
    chk("rst_count",     64'(cnt), 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    rst8 = 1'b0;

    // Single transfer
    iv = 1'b1; id = 48'h0000_0000_00FF; ordy = 1'b1;
    @(negedge clk);
    chk("single_valid", 64'(ov), 64'd1);
    chk("single_data",  64'(od), 64'hFF);
    chk("single_zero",  64'(oz), 64'd0);
    iv = 1'b0;
    @(negedge clk);
    chk("single_count",     64'(cnt), 64'd1);
    chk("single_empty",     64'(ov),  64'd0);

    // Backpressure
    do_reset();
    ordy = 1'b0; iv = 1'b1; id = 48'h1;
    @(negedge clk);
    chk("bp_ready_one", 64'(ir), 64'd1);
    id = 48'h2;
    @(negedge clk);
    chk("bp_ready_full", 64'(ir), 64'd0);
    chk("bp_data0",      64'(od), 64'h1);
    iv = 1'b0; ordy = 1'b1;
    @(negedge clk);
    chk("bp_data1",       64'(od), 64'h2);
    chk("bp_ready_again", 64'(ir), 64'd1);
    @(negedge clk);
    chk("bp_count", 64'(cnt), 64'd2);
    chk("bp_empty", 64'(ov),  64'd0);

    // Streaming
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("stream_valid", 64'(ov), 64'd1);
        chk("stream_ready", 64'(ir), 64'd1);
        chk("stream_data",  64'(od), 64'(1000 + i - 1));
      end
      iv = 1'b1; ordy = 1'b1; id = 48'(1000 + i);
    end
    @(negedge clk);
    chk("stream_last", 64'(od), 64'(1099));
    iv = 1'b0;
    @(negedge clk);
    chk("stream_count", 64'(cnt), 64'd100);
    chk("stream_empty", 64'(ov),  64'd0);

    // Zero flag
    do_reset();
    ordy = 1'b0; iv = 1'b1; id = 48'h0;
    @(negedge clk);
    chk("zero_first", 64'(oz), 64'd1);
    id = 48'hFFFF_FFFF_FFFF;
    @(negedge clk);
    chk("zero_hold", 64'(oz), 64'd1);
    iv = 1'b0; ordy = 1'b1;
    @(negedge clk);
    chk("zero_second",      64'(oz), 64'd0);
    chk("zero_second_data", 64'(od), 64'hFFFF_FFFF_FFFF);
    @(negedge clk);
    ordy = 1'b0;

    // Reset mid-operation from FULL with count=5
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      iv = 1'b1; ordy = 1'b1; id = 48'(i + 7);
    end
    @(negedge clk);
    ordy = 1'b0; id = 48'h77;
    @(negedge clk);
    chk("mid_count5", 64'(cnt), 64'd5);
    chk("mid_full",   64'(ir),  64'd0);
    iv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(ov),  64'd0);
    chk("mid_rst_ready", 64'(ir),  64'd1);
    chk("mid_rst_count", 64'(cnt), 64'd0);
    chk("mid_rst_data",  64'(od),  64'd0);
    @(negedge clk);
    rst = 1'b0; iv = 1'b1; id = 48'h55;
    @(negedge clk);
    chk("post_rst_valid", 64'(ov),  64'd1);
    chk("post_rst_data",  64'(od),  64'h55);
    chk("post_rst_count", 64'(cnt), 64'd0);
    iv = 1'b0;

    // Narrow width and counter wrap
    for (int i = 0; i <= 65536; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 256) chk("w8_data", 64'(od8), 64'((i - 1) % 256));
      if (i == 65536) chk("w8_count_max", 64'(cnt8), 64'hFFFF);
      iv8 = 1'b1; or8 = 1'b1; id8 = 8'(i);
    end
    @(negedge clk);
    chk("w8_count_wrap", 64'(cnt8), 64'd0);
    chk("w8_last_data",  64'(od8),  64'd0);
    iv8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
